// File: rtl/dps_strap_ctrl.sv
// Debug pad-group strap sequencer: debounces mode/boot straps, holds reset, steers DPS pad mux.
// Optional build macro STRAP_OVERRIDE_EN adds override_* inputs used at the latch point.
module dps_strap_ctrl #(
    parameter int DebounceCycles = 1024,
    parameter int HoldCycles     = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       strap_spi_i,
    input  logic       strap_boot_i,
    input  logic       relatch_req_i,
`ifdef STRAP_OVERRIDE_EN
    input  logic       override_en_i,
    input  logic       override_spi_i,
    input  logic       override_boot_i,
`endif
    output logic       mode_spi_o,
    output logic       bootstrap_o,
    output logic       straps_valid_o,
    output logic       jtag_en_o,
    output logic       spi_en_o,
    output logic       sys_rst_no,
    output logic [1:0] state_o
);

    localparam int DbW   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam int HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

    localparam logic [DbW-1:0]   DbLast   = DbW'(DebounceCycles - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    logic [1:0]       sync_q1;
    logic [1:0]       sync_q2;
    logic [1:0]       pair_prev;
    logic             pair_same;
    logic [1:0]       latch_pair;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [DbW-1:0]   db_cnt_q;
    logic [DbW-1:0]   db_cnt_d;
    logic [HoldW-1:0] hold_cnt_q;
    logic [HoldW-1:0] hold_cnt_d;
    logic             latch_en;
    logic             run_enter;
    logic             run_exit;

    // {spi,boot} travel together so both bits debounce as one pair
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1   <= 2'b00;
            sync_q2   <= 2'b00;
            pair_prev <= 2'b00;
        end else begin
            sync_q1   <= {strap_spi_i, strap_boot_i};
            sync_q2   <= sync_q1;
            pair_prev <= sync_q2;
        end
    end

    assign pair_same = (sync_q2 == pair_prev);

`ifdef STRAP_OVERRIDE_EN
    assign latch_pair = override_en_i ? {override_spi_i, override_boot_i}
                                      : sync_q2;
`else
    assign latch_pair = sync_q2;
`endif

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        latch_en   = 1'b0;
        run_enter  = 1'b0;
        run_exit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d  = ST_SAMPLE;
                db_cnt_d = '0;
            end
            ST_SAMPLE: begin
                if (relatch_req_i || !pair_same) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DbLast) begin
                    latch_en   = 1'b1;
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end
            ST_HOLD: begin
                if (relatch_req_i) begin
                    state_d  = ST_SAMPLE;
                    db_cnt_d = '0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d   = ST_RUN;
                    run_enter = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            ST_RUN: begin
                if (relatch_req_i) begin
                    state_d  = ST_SAMPLE;
                    db_cnt_d = '0;
                    run_exit = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_spi_o  <= 1'b0;
            bootstrap_o <= 1'b0;
        end else if (latch_en) begin
            mode_spi_o  <= latch_pair[1];
            bootstrap_o <= latch_pair[0];
        end
    end

    // Leaving RUN drops both enables at once so the pads are never double-driven
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sys_rst_no     <= 1'b0;
            straps_valid_o <= 1'b0;
            jtag_en_o      <= 1'b0;
            spi_en_o       <= 1'b0;
        end else if (run_enter) begin
            sys_rst_no     <= 1'b1;
            straps_valid_o <= 1'b1;
            jtag_en_o      <= ~mode_spi_o;
            spi_en_o       <= mode_spi_o;
        end else if (run_exit) begin
            sys_rst_no     <= 1'b0;
            straps_valid_o <= 1'b0;
            jtag_en_o      <= 1'b0;
            spi_en_o       <= 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_dps_strap_ctrl.sv
// Randomized bench for dps_strap_ctrl against an edge-numbered reference model.
// Build with STRAP_OVERRIDE_EN defined to exercise the override inputs.
module tb_dps_strap_ctrl;

    localparam int DB = 8;
    localparam int HC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strap_spi = 1'b0;
    logic       strap_boot = 1'b0;
    logic       relatch = 1'b0;
`ifdef STRAP_OVERRIDE_EN
    logic       ovr_en = 1'b0;
    logic       ovr_spi = 1'b0;
    logic       ovr_boot = 1'b0;
`endif
    logic       mode_spi;
    logic       bootstrap;
    logic       valid;
    logic       jtag_en;
    logic       spi_en;
    logic       sys_rst_n;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dps_strap_ctrl #(
        .DebounceCycles(DB),
        .HoldCycles(HC)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .strap_spi_i(strap_spi),
        .strap_boot_i(strap_boot),
        .relatch_req_i(relatch),
`ifdef STRAP_OVERRIDE_EN
        .override_en_i(ovr_en),
        .override_spi_i(ovr_spi),
        .override_boot_i(ovr_boot),
`endif
        .mode_spi_o(mode_spi),
        .bootstrap_o(bootstrap),
        .straps_valid_o(valid),
        .jtag_en_o(jtag_en),
        .spi_en_o(spi_en),
        .sys_rst_no(sys_rst_n),
        .state_o(state)
    );

    // Model: rh holds the last three raw samples; the synced pair seen at an
    // edge is the second newest, its previous value the oldest.
    logic [1:0] rh [3];
    int         m_ph;
    int         m_edge;
    int         m_base;
    int         m_run_at;
    logic       m_mode;
    logic       m_boot;
    logic [1:0] m_pick;

`ifdef STRAP_OVERRIDE_EN
    assign m_pick = ovr_en ? {ovr_spi, ovr_boot} : rh[1];
`else
    assign m_pick = rh[1];
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rh[0]    <= 2'b00;
            rh[1]    <= 2'b00;
            rh[2]    <= 2'b00;
            m_ph     <= 0;
            m_edge   <= 0;
            m_base   <= 0;
            m_run_at <= 0;
            m_mode   <= 1'b0;
            m_boot   <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            rh[0]  <= rh[1];
            rh[1]  <= rh[2];
            rh[2]  <= {strap_spi, strap_boot};
            case (m_ph)
                0: begin
                    m_ph   <= 1;
                    m_base <= m_edge + 1;
                end
                1: begin
                    if (relatch || rh[1] != rh[0]) begin
                        m_base <= m_edge + 1;
                    end else if (m_edge + 1 - m_base == DB) begin
                        m_mode   <= m_pick[1];
                        m_boot   <= m_pick[0];
                        m_ph     <= 2;
                        m_run_at <= m_edge + 1 + HC;
                    end
                end
                2: begin
                    if (relatch) begin
                        m_ph   <= 1;
                        m_base <= m_edge + 1;
                    end else if (m_edge + 1 == m_run_at) begin
                        m_ph <= 3;
                    end
                end
                default: begin
                    if (relatch) begin
                        m_ph   <= 1;
                        m_base <= m_edge + 1;
                    end
                end
            endcase
        end
    end

    logic [7:0] dut_vec;
    logic [7:0] exp_vec;
    logic       m_run;

    assign m_run   = (m_ph == 3);
    assign dut_vec = {state, mode_spi, bootstrap, valid,
                      jtag_en, spi_en, sys_rst_n};
    assign exp_vec = {2'(m_ph), m_mode, m_boot, m_run,
                      m_run & ~m_mode, m_run & m_mode, m_run};

    always @(negedge clk) begin
        n_tests = n_tests + 2;
        if (dut_vec !== exp_vec) begin
            n_fail = n_fail + 1;
            $display("FAIL model_cmp t=%0t dut=%b model=%b",
                     $time, dut_vec, exp_vec);
        end
        if (jtag_en && spi_en) begin
            n_fail = n_fail + 1;
            $display("FAIL mux_excl t=%0t both enables high", $time);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests = n_tests + 1;
        if (got != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic wait_state(input int st, input int budget,
                              input string name);
        int n;
        n = 0;
        while (int'(state) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(state), st);
    endtask

    task automatic do_reset(input logic spi, input logic boot);
        rst_n      = 1'b0;
        relatch    = 1'b0;
        strap_spi  = spi;
        strap_boot = boot;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_relatch();
        relatch = 1'b1;
        @(negedge clk);
        relatch = 1'b0;
    endtask

    int         n;
    int         bad;
    logic [7:0] snap;

    initial begin
        // Straps {1,1} stable from reset
        do_reset(1'b1, 1'b1);
        n = 0;
        while (!sys_rst_n && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("boot_latency_lo", int'(n >= DB + HC), 1);
        chk("boot_latency_hi", int'(n <= DB + HC + 4), 1);
        chk("t1_mode", int'(mode_spi), 1);
        chk("t1_boot", int'(bootstrap), 1);
        chk("t1_spi_en", int'(spi_en), 1);
        chk("t1_jtag_en", int'(jtag_en), 0);
        chk("t1_state", int'(state), 3);

        // Mode strap toggling every 5 cycles keeps the block in SAMPLE
        do_reset(1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) strap_spi = ~strap_spi;
            @(negedge clk);
            if (state != 2'd1) bad++;
        end
        chk("t2_stay_sample", bad, 0);
        n = 0;
        while (state == 2'd1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t2_settle_cycles", n, 6);
        wait_state(3, 20, "t2_reach_run");
        chk("t2_mode", int'(mode_spi), 0);
        chk("t2_jtag_en", int'(jtag_en), 1);
        chk("t2_spi_en", int'(spi_en), 0);

        // Strap flip ignored in RUN
        strap_spi = 1'b1;
        snap = dut_vec;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (dut_vec != snap) bad++;
        end
        chk("t3_run_frozen", bad, 0);

        // Relatch from RUN(JTAG) with mode strap now SPI
        pulse_relatch();
        chk("t4_state", int'(state), 1);
        chk("t4_rst", int'(sys_rst_n), 0);
        chk("t4_jtag_off", int'(jtag_en), 0);
        chk("t4_spi_off", int'(spi_en), 0);
        chk("t4_mode_kept", int'(mode_spi), 0);
        wait_state(3, 40, "t4_reach_run");
        chk("t4_spi_en", int'(spi_en), 1);
        chk("t4_mode", int'(mode_spi), 1);

        // Async reset during HOLD
        pulse_relatch();
        wait_state(2, 40, "t5_reach_hold");
        #2 rst_n = 1'b0;
        #1 chk("t5_reset_vals", int'(dut_vec), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_state(3, 40, "t5_reach_run");
        chk("t5_mode", int'(mode_spi), 1);
        chk("t5_boot", int'(bootstrap), 0);

        // Random straps, relatch pulses and occasional async resets
        do_reset(1'($urandom), 1'($urandom));
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            relatch = ($urandom % 90 == 0);
            if ($urandom % ((i < 2000) ? 12 : 40) == 0) begin
                if ($urandom % 2 == 0) strap_spi = ~strap_spi;
                else strap_boot = ~strap_boot;
            end
            if ($urandom % 700 == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        relatch = 1'b0;

`ifdef STRAP_OVERRIDE_EN
        ovr_en   = 1'b1;
        ovr_spi  = 1'b1;
        ovr_boot = 1'b1;
        do_reset(1'b0, 1'b0);
        wait_state(3, 40, "ovr_reach_run");
        chk("ovr_mode", int'(mode_spi), 1);
        chk("ovr_boot", int'(bootstrap), 1);
        chk("ovr_spi_en", int'(spi_en), 1);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
